vec_mem_responder: RTL and testbench

Memory-side responder for the vector processor's MEM stage. It accepts a 192-bit vector load or store request, using the same `mem[3:0]` encoding the MEM stage drives. It serializes the request into 8 lane beats against an internal 24-bit-wide data array and returns a one-cycle `done` pulse, with `rdata` valid for loads. It sits directly behind MEM_Stage, replacing a single-cycle flat memory with a realistic multi-cycle port.

---
 rtl/vec_mem_responder.sv | 155 +++++++++++++++
 tb/tb_vec_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_responder.sv
// vec_mem_responder: multi-cycle memory port behind the vector MEM stage.
// Accepts one 192-bit load/store, serializes it into 8 lane beats against a
// 24-bit-wide internal array, then pulses done for one cycle.
// Optional feature macro: VEC_STORE_FWD_EN (last-store forward register that
// lets an exact-address load complete without the 8-beat transfer).
module vec_mem_responder #(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned LANE_W = 24,
  parameter int unsigned LANES  = 8,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               mem,
  input  logic [ADDR_W-1:0]        dirMem,
  input  logic [LANES*LANE_W-1:0]  wdata,
  output logic [LANES*LANE_W-1:0]  rdata,
  output logic                     done,
  output logic                     busy
);

  localparam int unsigned DATA_W = LANES * LANE_W;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned BEAT_W = $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_addr;
  logic                r_store;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_done;
  logic                r_busy;
  logic [LANE_W-1:0]   r_array [DEPTH];

  logic                w_accept;
  logic                w_fwd_hit;
  logic                w_beat_last;
  logic [IDX_W-1:0]    w_idx;
  logic [LANE_W-1:0]   w_wlane;
  logic                w_unused;

  assign w_accept    = (r_state == S_IDLE) && mem[3];
  assign w_idx       = r_addr + IDX_W'(r_beat);
  assign w_wlane     = r_wdata[32'(r_beat) * LANE_W +: LANE_W];
  assign w_beat_last = (r_beat == BEAT_W'(LANES - 1));
  // Request-type bits and address bits above the array index carry no meaning here.
  assign w_unused    = &{1'b0, mem[2:1], dirMem[ADDR_W-1:IDX_W]};

`ifdef VEC_STORE_FWD_EN
  logic [DATA_W-1:0]   r_fwd_data;
  logic [ADDR_W-1:0]   r_fwd_addr;
  logic [ADDR_W-1:0]   r_req_addr;
  logic                r_fwd_valid;

  // Only a load to exactly the last completed store address can use the forward copy.
  assign w_fwd_hit = r_fwd_valid && !mem[0] && (dirMem == r_fwd_addr);

  // Capture full request address and refresh the forward copy as each store finishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_addr  <= '0;
      r_fwd_addr  <= '0;
      r_fwd_data  <= '0;
      r_fwd_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req_addr <= dirMem;
      end
      if ((r_state == S_XFER) && w_beat_last && r_store) begin
        r_fwd_data  <= r_wdata;
        r_fwd_addr  <= r_req_addr;
        r_fwd_valid <= 1'b1;
      end
    end
  end
`else
  assign w_fwd_hit = 1'b0;
`endif

  // Next-state logic: IDLE accepts, XFER runs 8 beats, DONE lasts one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem[3]) begin
          w_next = w_fwd_hit ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        if (w_beat_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, request latch, beat counter, load data and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_store <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_beat  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE);
      r_busy  <= (w_next != S_IDLE);
      if (w_accept) begin
        r_addr  <= dirMem[IDX_W-1:0];
        r_store <= mem[0];
        r_beat  <= '0;
        if (mem[0]) begin
          r_wdata <= wdata;
        end
`ifdef VEC_STORE_FWD_EN
        if (w_fwd_hit) begin
          r_rdata <= r_fwd_data;
        end
`endif
      end
      if (r_state == S_XFER) begin
        r_beat <= r_beat + BEAT_W'(1);
        if (!r_store) begin
          r_rdata[32'(r_beat) * LANE_W +: LANE_W] <= r_array[w_idx];
        end
      end
    end
  end

  // Store beats write one lane per edge; the array keeps its contents through reset.
  always_ff @(posedge clk) begin
    if ((r_state == S_XFER) && r_store) begin
      r_array[w_idx] <= w_wlane;
    end
  end

  assign rdata = r_rdata;
  assign done  = r_done;
  assign busy  = r_busy;

endmodule

// File: tb/tb_vec_mem_responder.sv
// Testbench for vec_mem_responder: transaction-level reference model plus
// directed scenarios with hand-computed expectations.
module tb_vec_mem_responder;

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned LANE_W = 24;
  localparam int unsigned LANES  = 8;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned DATA_W = LANES * LANE_W;
`ifdef VEC_STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int LAT_NORM = 9;
  localparam int LAT_HIT  = FWD ? 1 : 9;

  localparam logic [DATA_W-1:0] D1 =
    192'h90aafe_1706fe_1700fe_1704fe_1703fe_1745fe_1764fe_554433;
  localparam logic [DATA_W-1:0] W2 =
    192'h0badc0_de1234_567890_abcdef_fedcba_987654_321000_111111;
  localparam logic [DATA_W-1:0] W3 =
    192'haaaaaa_bbbbbb_cccccc_dddddd_eeeeee_123123_456456_789789;
  localparam logic [DATA_W-1:0] W4 =
    192'h010101_020202_030303_040404_050505_060606_070707_080808;

  logic              clk    = 1'b0;
  logic              rst    = 1'b0;
  logic [3:0]        mem    = 4'b0000;
  logic [ADDR_W-1:0] dirMem = '0;
  logic [DATA_W-1:0] wdata  = '0;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              busy;

  int n_pass  = 0;
  int n_total = 0;

  vec_mem_responder #(
    .ADDR_W(ADDR_W), .LANE_W(LANE_W), .LANES(LANES), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .mem(mem), .dirMem(dirMem),
    .wdata(wdata), .rdata(rdata), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [LANE_W-1:0] m_arr [DEPTH];
  int                m_age   = -1;   // edges since accept, -1 when idle
  int                m_lat   = 8;    // edges from accept to completion
  bit                m_store = 1'b0;
  logic [9:0]        m_addr  = '0;
  logic [ADDR_W-1:0] m_full  = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [DATA_W-1:0] m_rdata = '0;
  bit                m_busy  = 1'b0;
  bit                m_done  = 1'b0;
  bit                m_fv    = 1'b0;
  logic [ADDR_W-1:0] m_faddr = '0;
  logic [DATA_W-1:0] m_fdata = '0;

  function automatic logic [DATA_W-1:0] read_vec(input logic [9:0] a);
    logic [DATA_W-1:0] v;
    logic [9:0] ix;
    for (int i = 0; i < LANES; i++) begin
      ix = a + 10'(i);
      v[i*LANE_W +: LANE_W] = m_arr[ix];
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_age = -1; m_busy = 1'b0; m_done = 1'b0; m_rdata = '0; m_fv = 1'b0;
    end else if (m_age < 0) begin
      m_done = 1'b0;
      if (mem[3]) begin
        m_store = mem[0];
        m_full  = dirMem;
        m_addr  = dirMem[9:0];
        m_wdata = wdata;
        m_lat   = (FWD && m_fv && !mem[0] && (dirMem == m_faddr)) ? 1 : 8;
        m_age   = 0;
        m_busy  = 1'b1;
      end
    end else begin
      m_age++;
      if (m_age > m_lat) begin
        m_age = -1; m_busy = 1'b0; m_done = 1'b0;
      end else begin
        if (m_store) begin
          logic [9:0] ix;
          ix = m_addr + 10'(m_age - 1);
          m_arr[ix] = m_wdata[(m_age-1)*LANE_W +: LANE_W];
        end
        if (m_age == m_lat) begin
          m_done = 1'b1;
          if (m_store) begin
            m_fv = 1'b1; m_faddr = m_full; m_fdata = m_wdata;
          end else begin
            m_rdata = (m_lat == 1) ? m_fdata : read_vec(m_addr);
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("busy", DATA_W'(busy), DATA_W'(m_busy));
    check("done", DATA_W'(done), DATA_W'(m_done));
    if (!m_busy || m_done) check("rdata", rdata, m_rdata);
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(inout int n);
    bit seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic do_req(input bit st, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input int exp_lat,
                        input string nm);
    int n = 0;
    @(posedge clk); #1;
    mem = {1'b1, 2'b00, st}; dirMem = a; wdata = d;
    @(posedge clk); #1;
    mem = 4'b0000;
    wait_done(n);
    check({nm, " latency"}, DATA_W'(n), DATA_W'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    // reset held
    repeat (2) @(negedge clk);
    check("reset busy", DATA_W'(busy), '0);
    check("reset done", DATA_W'(done), '0);
    check("reset rdata", rdata, '0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle busy", DATA_W'(busy), '0);
    end

    // store then load
    do_req(1'b1, 21'd3, D1, LAT_NORM, "st3");
    check("arr3", DATA_W'(m_arr[3]), 192'h554433);
    check("arr10", DATA_W'(m_arr[10]), 192'h90aafe);
    do_req(1'b0, 21'd3, '0, LAT_HIT, "ld3");
    check("ld3 data", rdata, D1);

    // wrap-around
    do_req(1'b1, 21'(DEPTH - 2), 192'h1, LAT_NORM, "stwrap");
    check("arr1022", DATA_W'(m_arr[1022]), 192'h1);
    check("arr1023", DATA_W'(m_arr[1023]), 192'h0);
    check("arr0", DATA_W'(m_arr[0]), 192'h0);
    do_req(1'b0, 21'h1ffffe, '0, LAT_NORM, "ldwrap");
    check("ldwrap data", rdata, 192'h1);

    // reset in the middle of a store
    @(posedge clk); #1;
    mem = 4'b1001; dirMem = '0; wdata = '1;
    @(posedge clk); #1;
    mem = 4'b0000;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort busy", DATA_W'(busy), '0);
    check("abort done", DATA_W'(done), '0);
    check("abort rdata", rdata, '0);
    @(posedge clk); #1 rst = 1'b1;

    // load addr 0 while inputs change during the transfer
    @(posedge clk); #1;
    mem = 4'b1000; dirMem = '0;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    dirMem = 21'd5; mem = 4'b1001; wdata = W2;
    n = 2;
    wait_done(n);
    check("busyload latency", DATA_W'(n), DATA_W'(LAT_NORM));
    check("busyload data", rdata,
          {24'h1704fe, 24'h1703fe, 24'h0, 24'h0, {4{24'hffffff}}});
    @(posedge clk);
    @(negedge clk);
    check("no accept at T+9", DATA_W'(busy), '0);
    @(posedge clk); #1;
    mem = 4'b0000;
    @(negedge clk);
    check("accept at T+10", DATA_W'(busy), DATA_W'(1));
    n = 1;
    wait_done(n);
    check("st5 latency", DATA_W'(n), DATA_W'(LAT_NORM));
    @(posedge clk); #1;
    do_req(1'b0, 21'd5, '0, LAT_HIT, "ld5");
    check("ld5 data", rdata, W2);
    do_req(1'b0, 21'd0, '0, LAT_NORM, "ld0");
    check("ld0 data", rdata, {W2[71:0], 24'h0, {4{24'hffffff}}});

    // forward-path latency vs. normal path
    do_req(1'b1, 21'd9, W4, LAT_NORM, "st9");
    do_req(1'b1, 21'd7, W3, LAT_NORM, "st7");
    do_req(1'b0, 21'd7, '0, LAT_HIT, "ld7");
    check("ld7 data", rdata, W3);
    do_req(1'b0, 21'd8, '0, LAT_NORM, "ld8");
    check("ld8 data", rdata, {24'h020202, W3[191:24]});

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
